axis_uart_rx_gen2: RTL and testbench
====================================

AXIS_UART_RX_GEN2 -- requirements
Module: axis_uart_rx_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning character width in bits (legal range 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of 2, at least 2).
REQ-003 SHALL have ports clk  in  1  clock; rst  in  1  reset. The design uses one clock; reset is synchronous and active-high.
REQ-004 SHALL have port uart_rx  in  1  serial line; idle is high.
REQ-005 SHALL have ports delitel  in  32  clk cycles per bit; stop_bit_num  in  32  stop bits (2 selects two, any other value selects one); parity_bit_mode  in  3  parity mode (0 zero, 1 one, 2 odd, 3 even, 4..7 none).
REQ-006 SHALL have ports maxis_tready_i  in  1; maxis_tvalid_o  out  1; maxis_data_o  out  DATA_W; maxis_tuser_o  out  2  {frame_err, parity_err} of that character.
REQ-007 SHALL have ports err_parity_cnt, err_frame_cnt, err_drop_cnt  out  32  each; each is a saturating event counter.
REQ-008 SHALL have port fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-009 SHALL synchronise uart_rx through 2 flops; the synchroniser output is the only line sample used.
REQ-010 SHALL implement the FSM IDLE->START->DATA->PARITY->STOP->IDLE; PARITY is skipped when the mode is none.
REQ-011 SHALL leave IDLE on the first synchronised low sample, and latch delitel, stop_bit_num and parity mode at that transition; the latched values hold until the frame ends.
REQ-012 SHALL clamp a latched delitel below 4 to 4.
REQ-013 SHALL run a bit counter 0..delitel-1 and take the bit sample when the counter equals delitel>>1.
REQ-014 SHALL return from START to IDLE without pushing or counting anything if the mid-start sample is high (false start).
REQ-015 SHALL shift DATA_W bits LSB-first.
REQ-016 SHALL set parity_err when the parity sample differs from the expected value: 0 for zero, 1 for mark, ~^data for odd, ^data for even.
REQ-017 SHALL set frame_err if any required stop sample is low; with two stop bits, both are checked.
REQ-018 SHALL push {frame_err, parity_err, data} into the FIFO on the cycle after the final stop sample; errored characters are still pushed.
REQ-019 SHALL re-arm IDLE on the cycle after the final stop sample, so back-to-back frames are received with no idle gap.
REQ-020 SHALL, when the FIFO is full and no pop occurs in the same cycle, drop the character and increment err_drop_cnt. A same-cycle push and pop on a full FIFO SHALL be accepted.
REQ-021 SHALL make the FIFO first-word-fall-through: maxis_tvalid_o asserts 1 cycle after a push into an empty FIFO.
REQ-022 SHALL pop on tvalid&&tready; data and tuser SHALL stay stable while tvalid=1 and tready=0.
REQ-023 SHALL increment err_parity_cnt and err_frame_cnt once per pushed or dropped character flagged with that error; all three counters saturate at 0xFFFFFFFF.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, in any state including mid-frame: enter IDLE, empty the FIFO, clear all counters, drive maxis_tvalid_o=0 and fifo_level_o=0, and set synchroniser flops to 1.
REQ-025 SHALL reset maxis_data_o and maxis_tuser_o to 0; no frame in progress at reset is pushed.

Configuration
REQ-026 SHALL, with UART_RX_MAJORITY_EN defined, take each bit as the 2-of-3 majority of samples at (delitel>>1)-1, delitel>>1 and (delitel>>1)+1.
REQ-027 SHALL, without UART_RX_MAJORITY_EN, use the single sample at delitel>>1; ports and latency are identical in both builds.

Structure
REQ-028 SHALL place the FSM state enum, the parity-mode constants (PAR_ZERO, PAR_ONE, PAR_ODD, PAR_EVEN, PAR_NONE) and a tuser bit-index constant in package uart_pkg.
REQ-029 SHALL implement the FIFO as sub-module axis_uart_rx_fifo, parametrised by width DATA_W+2 and FIFO_DEPTH.

Verification
REQ-030 SHALL cover: delitel=16, 8N1, char 0xA5 -> one beat, data=0xA5, tuser=00, 0 cycles of tvalid before the frame completes.
REQ-031 SHALL cover: even parity, 0x03 sent with parity bit 1 -> tuser=01, err_parity_cnt=1; odd parity with a correct bit -> tuser=00.
REQ-032 SHALL cover: stop bit forced low on 0x55 -> tuser=10, err_frame_cnt=1; next clean frame 0x56 -> tuser=00.
REQ-033 SHALL cover: FIFO_DEPTH=4, tready=0, 6 chars sent -> fifo_level_o=4, err_drop_cnt=2; releasing tready drains the first 4 chars in order.
REQ-034 SHALL cover: 0.25-bit low glitch while idle -> no push and no error; rst pulsed mid-DATA -> tvalid=0, all counters 0, next frame received correctly.
REQ-035 SHALL cover: DATA_W=9, 2 stop bits, 0x1FF -> data=0x1FF; in the UART_RX_MAJORITY_EN build, a 1-cycle mid-bit glitch does not corrupt the result.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the AXI-Stream UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic [2:0] PAR_ZERO = 3'd0;
    localparam logic [2:0] PAR_ONE  = 3'd1;
    localparam logic [2:0] PAR_ODD  = 3'd2;
    localparam logic [2:0] PAR_EVEN = 3'd3;
    localparam logic [2:0] PAR_NONE = 3'd4;

    // Position of each error flag inside tuser / above the data in a FIFO word.
    localparam int unsigned TUSER_PAR_BIT = 0;
    localparam int unsigned TUSER_FRM_BIT = 1;
    localparam int unsigned TUSER_W       = 2;

    // Modes 4..7 all mean "no parity bit on the line".
    function automatic logic par_is_none(input logic [2:0] mode);
        return (mode >= PAR_NONE);
    endfunction

endpackage

// File: rtl/axis_uart_rx_fifo.sv
// First-word-fall-through receive FIFO; full-FIFO writes are dropped unless a pop happens in the same cycle.
module axis_uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             valid_q;
    logic             full_c, do_wr_c, do_rd_c;

    // Accept/drop decision and next occupancy.
    always_comb begin
        full_c  = (count_q == (AW+1)'(DEPTH));
        do_rd_c = rd_en && valid_q;
        do_wr_c = wr_en && (!full_c || do_rd_c);
        drop_c  = wr_en && full_c && !do_rd_c;
        count_d = count_q + (AW+1)'(do_wr_c) - (AW+1)'(do_rd_c);
    end

    // Pointers, occupancy and registered valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr_c) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_valid  = valid_q;
    assign rd_data_c = valid_q ? mem[rd_ptr_q] : '0;
    assign level     = count_q;

endmodule

// File: rtl/axis_uart_rx_gen2.sv
// UART receiver with AXI-Stream output FIFO and saturating error counters.
// Optional build macro UART_RX_MAJORITY_EN: each bit becomes a 2-of-3 vote
// around mid-bit; the decision point (and so latency) is the same in both builds.
module axis_uart_rx_gen2 #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic [31:0]                   delitel,
    input  logic [31:0]                   stop_bit_num,
    input  logic [2:0]                    parity_bit_mode,
    input  logic                          maxis_tready_i,
    output logic                          maxis_tvalid_o,
    output logic [DATA_W-1:0]             maxis_data_o,
    output logic [1:0]                    maxis_tuser_o,
    output logic [31:0]                   err_parity_cnt,
    output logic [31:0]                   err_frame_cnt,
    output logic [31:0]                   err_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    import uart_pkg::*;

    localparam int unsigned IDX_W   = $clog2(DATA_W);
    localparam int unsigned WORD_W  = DATA_W + TUSER_W;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]        sync_q;
    logic              rx_s;
    rx_state_t         state_q, state_d;
    logic [31:0]       cnt_q, cnt_d, div_q, div_d, half_c;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              stop2_q, stop2_d, stop_idx_q, stop_idx_d;
    logic [2:0]        par_q, par_d;
    logic              par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic              push_q, push_d;
    logic [WORD_W-1:0] word_q, word_d, fifo_rd_data;
    logic              s1_q, bit_c, decide_c, bit_end_c, exp_par_c, fifo_drop;

    // Two-flop synchroniser, idles high.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], uart_rx};
    end
    assign rx_s = sync_q[1];

    assign half_c    = div_q >> 1;
    assign decide_c  = (state_q != ST_IDLE) && (cnt_q == half_c + 32'd1);
    assign bit_end_c = (cnt_q == div_q - 32'd1);

    // Mid-bit sample; the bit is decided one cycle later.
    always_ff @(posedge clk) begin
        if (rst)                                           s1_q <= 1'b1;
        else if (state_q != ST_IDLE && cnt_q == half_c)    s1_q <= rx_s;
    end

`ifdef UART_RX_MAJORITY_EN
    logic s0_q;
    // Early sample for the vote.
    always_ff @(posedge clk) begin
        if (rst)                                                  s0_q <= 1'b1;
        else if (state_q != ST_IDLE && cnt_q == half_c - 32'd1)   s0_q <= rx_s;
    end
    assign bit_c = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
`else
    assign bit_c = s1_q;
`endif

    // Expected parity bit for the latched mode.
    always_comb begin
        case (par_q)
            PAR_ZERO: exp_par_c = 1'b0;
            PAR_ONE:  exp_par_c = 1'b1;
            PAR_ODD:  exp_par_c = ~^shreg_q;
            default:  exp_par_c = ^shreg_q;
        endcase
    end

    // Frame FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = bit_end_c ? 32'd0 : cnt_q + 32'd1;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        push_d     = 1'b0;
        word_d     = word_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 32'd0;
                if (!rx_s) begin
                    state_d    = ST_START;
                    cnt_d      = 32'd1;
                    div_d      = (delitel < 32'd4) ? 32'd4 : delitel;
                    stop2_d    = (stop_bit_num == 32'd2);
                    par_d      = parity_bit_mode;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            ST_START: begin
                if (decide_c && bit_c) state_d = ST_IDLE;
                else if (bit_end_c)    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (decide_c) shreg_d = {bit_c, shreg_q[DATA_W-1:1]};
                if (bit_end_c) begin
                    if (bit_idx_q == IDX_W'(DATA_W - 1))
                        state_d = par_is_none(par_q) ? ST_STOP : ST_PARITY;
                    else
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            ST_PARITY: begin
                if (decide_c)  par_err_d = (bit_c != exp_par_c);
                if (bit_end_c) state_d   = ST_STOP;
            end
            ST_STOP: begin
                if (decide_c && !bit_c) frm_err_d = 1'b1;
                if (decide_c && (!stop2_q || stop_idx_q)) begin
                    state_d                        = ST_IDLE;
                    push_d                         = 1'b1;
                    word_d[DATA_W-1:0]             = shreg_q;
                    word_d[DATA_W + TUSER_PAR_BIT] = par_err_q;
                    word_d[DATA_W + TUSER_FRM_BIT] = frm_err_d;
                end else if (bit_end_c) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= 32'd4;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            par_q      <= PAR_NONE;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            push_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            push_q     <= push_d;
            word_q     <= word_d;
        end
    end

    // Saturating error counters; errors count whether the character is kept or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_parity_cnt <= '0;
            err_frame_cnt  <= '0;
            err_drop_cnt   <= '0;
        end else begin
            if (push_q && word_q[DATA_W + TUSER_PAR_BIT] && err_parity_cnt != CNT_MAX)
                err_parity_cnt <= err_parity_cnt + 32'd1;
            if (push_q && word_q[DATA_W + TUSER_FRM_BIT] && err_frame_cnt != CNT_MAX)
                err_frame_cnt <= err_frame_cnt + 32'd1;
            if (fifo_drop && err_drop_cnt != CNT_MAX)
                err_drop_cnt <= err_drop_cnt + 32'd1;
        end
    end

    axis_uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (push_q),
        .wr_data   (word_q),
        .rd_en     (maxis_tready_i),
        .rd_valid  (maxis_tvalid_o),
        .rd_data_c (fifo_rd_data),
        .level     (fifo_level_o),
        .drop_c    (fifo_drop)
    );

    assign maxis_data_o  = fifo_rd_data[DATA_W-1:0];
    assign maxis_tuser_o = fifo_rd_data[WORD_W-1:DATA_W];

endmodule

// File: tb/tb_axis_uart_rx_gen2.sv
// Directed bench for axis_uart_rx_gen2: an 8-bit/4-deep and a 9-bit/4-deep instance.
module tb_axis_uart_rx_gen2;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst, rx8, rx9, tready;
    logic [31:0] delitel, stop_bit_num;
    logic [2:0]  par_mode;

    logic        tv8, tv9;
    logic [7:0]  data8;
    logic [8:0]  data9;
    logic [1:0]  tuser8, tuser9;
    logic [31:0] par8, frm8, drop8, par9, frm9, drop9;
    logic [2:0]  lvl8, lvl9;

    int n_cmp = 0;
    int n_bad = 0;
    int tv8_cnt = 0;
    int tv_snap = 0;
    logic [10:0] q8[$];
    logic [10:0] q9[$];

    always #5 clk = ~clk;

    axis_uart_rx_gen2 #(.DATA_W(8), .FIFO_DEPTH(4)) u_dut8 (
        .clk(clk), .rst(rst), .uart_rx(rx8), .delitel(delitel), .stop_bit_num(stop_bit_num),
        .parity_bit_mode(par_mode), .maxis_tready_i(tready), .maxis_tvalid_o(tv8),
        .maxis_data_o(data8), .maxis_tuser_o(tuser8), .err_parity_cnt(par8),
        .err_frame_cnt(frm8), .err_drop_cnt(drop8), .fifo_level_o(lvl8)
    );

    axis_uart_rx_gen2 #(.DATA_W(9), .FIFO_DEPTH(4)) u_dut9 (
        .clk(clk), .rst(rst), .uart_rx(rx9), .delitel(delitel), .stop_bit_num(stop_bit_num),
        .parity_bit_mode(par_mode), .maxis_tready_i(tready), .maxis_tvalid_o(tv9),
        .maxis_data_o(data9), .maxis_tuser_o(tuser9), .err_parity_cnt(par9),
        .err_frame_cnt(frm9), .err_drop_cnt(drop9), .fifo_level_o(lvl9)
    );

    // Record every accepted beat as {tuser, data}, mid-cycle.
    always @(negedge clk) begin
        if (tv8) tv8_cnt = tv8_cnt + 1;
        if (tv8 && tready) q8.push_back({tuser8, 1'b0, data8});
        if (tv9 && tready) q9.push_back({tuser9, data9});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit sel9, input logic v);
        if (sel9) rx9 = v;
        else      rx8 = v;
    endtask

    task automatic send_bit(input bit sel9, input logic v, input int div);
        drive(sel9, v);
        tick(div);
    endtask

    task automatic send_frame(input bit sel9, input logic [8:0] d, input int nd,
                              input bit has_par, input logic par_bit, input int nstop,
                              input logic [1:0] stop_v, input int div, input int glitch);
        send_bit(sel9, 1'b0, div);
        for (int i = 0; i < nd; i++) begin
            if (i == glitch) begin
                drive(sel9, d[i]);  tick(8);
                drive(sel9, ~d[i]); tick(1);
                drive(sel9, d[i]);  tick(div - 9);
            end else begin
                send_bit(sel9, d[i], div);
            end
        end
        if (has_par) send_bit(sel9, par_bit, div);
        tv_snap = tv8_cnt;
        for (int i = 0; i < nstop; i++) send_bit(sel9, stop_v[i], div);
        drive(sel9, 1'b1);
        tick(2 * div);
    endtask

    task automatic wait_q(input bit sel9, input int n);
        int k = 0;
        while (((sel9 ? q9.size() : q8.size()) < n) && k < 400) begin
            tick(1);
            k++;
        end
        check_eq(sel9 ? "q9_beats" : "q8_beats", 32'(sel9 ? q9.size() : q8.size()), 32'(n));
    endtask

    task automatic get_beat(input bit sel9, output logic [10:0] v);
        v = 11'h7FF;
        if (sel9 && q9.size() > 0)       v = q9.pop_front();
        else if (!sel9 && q8.size() > 0) v = q8.pop_front();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] v;
        int tv_base;
        rst = 1'b1; rx8 = 1'b1; rx9 = 1'b1; tready = 1'b1;
        delitel = 32'(DIV); stop_bit_num = 32'd1; par_mode = 3'd4;
        tick(4);
        check_eq("rst_tvalid", 32'(tv8), 32'd0);
        check_eq("rst_level",  32'(lvl8), 32'd0);
        check_eq("rst_data",   32'(data8), 32'd0);
        check_eq("rst_tuser",  32'(tuser8), 32'd0);
        check_eq("rst_parcnt", par8, 32'd0);
        check_eq("rst_frmcnt", frm8, 32'd0);
        check_eq("rst_dropcnt", drop8, 32'd0);
        rst = 1'b0;
        tick(4);

        // 8N1 0xA5, no tvalid before the frame completes
        tv_base = tv8_cnt;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, DIV, -1);
        check_eq("a5_early_tvalid", 32'(tv_snap - tv_base), 32'd0);
        wait_q(0, 1);
        get_beat(0, v); check_eq("a5_beat", 32'(v), 32'h0A5);

        // even parity, wrong parity bit
        par_mode = 3'd3;
        send_frame(0, 9'h003, 8, 1, 1'b1, 1, 2'b11, DIV, -1);
        wait_q(0, 1);
        get_beat(0, v); check_eq("even_bad_beat", 32'(v), 32'h203);
        check_eq("even_bad_parcnt", par8, 32'd1);

        // odd parity, correct parity bit
        par_mode = 3'd2;
        send_frame(0, 9'h003, 8, 1, 1'b1, 1, 2'b11, DIV, -1);
        wait_q(0, 1);
        get_beat(0, v); check_eq("odd_ok_beat", 32'(v), 32'h003);
        check_eq("odd_ok_parcnt", par8, 32'd1);

        // stop bit low, then a clean frame
        par_mode = 3'd4;
        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b00, DIV, -1);
        wait_q(0, 1);
        get_beat(0, v); check_eq("stop_low_beat", 32'(v), 32'h455);
        check_eq("stop_low_frmcnt", frm8, 32'd1);
        send_frame(0, 9'h056, 8, 0, 1'b0, 1, 2'b11, DIV, -1);
        wait_q(0, 1);
        get_beat(0, v); check_eq("clean_beat", 32'(v), 32'h056);
        check_eq("clean_frmcnt", frm8, 32'd1);

        // overflow: 6 chars into a 4-deep FIFO with tready low
        tready = 1'b0;
        for (int i = 0; i < 6; i++)
            send_frame(0, 9'(9'h010 + i), 8, 0, 1'b0, 1, 2'b11, DIV, -1);
        check_eq("ovf_level", 32'(lvl8), 32'd4);
        check_eq("ovf_dropcnt", drop8, 32'd2);
        check_eq("ovf_tvalid", 32'(tv8), 32'd1);
        check_eq("ovf_data_held", 32'(data8), 32'h10);
        tready = 1'b1;
        wait_q(0, 4);
        for (int i = 0; i < 4; i++) begin
            get_beat(0, v);
            check_eq("ovf_drain", 32'(v), 32'(32'h010 + i));
        end
        tick(4);
        check_eq("ovf_level_empty", 32'(lvl8), 32'd0);

        // quarter-bit glitch while idle
        rx8 = 1'b0; tick(DIV / 4); rx8 = 1'b1;
        tick(3 * DIV);
        check_eq("glitch_no_beat", 32'(q8.size()), 32'd0);
        check_eq("glitch_tvalid", 32'(tv8), 32'd0);
        check_eq("glitch_parcnt", par8, 32'd1);
        check_eq("glitch_frmcnt", frm8, 32'd1);
        check_eq("glitch_dropcnt", drop8, 32'd2);

        // reset in the middle of the data bits
        send_bit(0, 1'b0, DIV);
        send_bit(0, 1'b1, DIV);
        send_bit(0, 1'b1, DIV);
        send_bit(0, 1'b0, DIV);
        rst = 1'b1; rx8 = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("midrst_tvalid", 32'(tv8), 32'd0);
        check_eq("midrst_level", 32'(lvl8), 32'd0);
        check_eq("midrst_parcnt", par8, 32'd0);
        check_eq("midrst_frmcnt", frm8, 32'd0);
        check_eq("midrst_dropcnt", drop8, 32'd0);
        tick(2 * DIV);
        check_eq("midrst_no_beat", 32'(q8.size()), 32'd0);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11, DIV, -1);
        wait_q(0, 1);
        get_beat(0, v); check_eq("after_rst_beat", 32'(v), 32'h03C);

        // divisor below 4 is clamped to 4
        delitel = 32'd0;
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11, 4, -1);
        wait_q(0, 1);
        get_beat(0, v); check_eq("clamp_beat", 32'(v), 32'h05A);
        delitel = 32'(DIV);
        tick(DIV);

        // 9-bit characters, two stop bits
        stop_bit_num = 32'd2;
        send_frame(1, 9'h1FF, 9, 0, 1'b0, 2, 2'b11, DIV, -1);
        wait_q(1, 1);
        get_beat(1, v); check_eq("w9_beat", 32'(v), 32'h1FF);
        send_frame(1, 9'h0AA, 9, 0, 1'b0, 2, 2'b01, DIV, -1);
        wait_q(1, 1);
        get_beat(1, v); check_eq("w9_stop2_low_beat", 32'(v), 32'h4AA);
        check_eq("w9_frmcnt", frm9, 32'd1);
`ifdef UART_RX_MAJORITY_EN
        send_frame(1, 9'h1FF, 9, 0, 1'b0, 2, 2'b11, DIV, 4);
        wait_q(1, 1);
        get_beat(1, v); check_eq("w9_glitch_beat", 32'(v), 32'h1FF);
`endif
        check_eq("w9_dropcnt", drop9, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
